// File: rtl/uparc_mem_arb_if.sv
// Bundle of every handshake/bus signal around uparc_mem_arb.
//   I-Port : i_IAddr, i_IRdC          -> o_IData, o_IRdy, o_IErr
//   D-Port : i_DAddr, i_DCmd, i_DRnW,
//            i_DBen, i_DData          -> o_DData, o_DRdy, o_DErr
//   Bus    : o_MAddr, o_MCmd, o_MRnW,
//            o_MBen, o_MData          <- i_MData, i_MRdy, i_MErr
// Signal names carry the arbiter's point of view: i_* enter the arbiter,
// o_* leave it.
//   slave  : the arbiter itself
//   master : the surroundings (CPU ports and memory) driving the arbiter
interface uparc_mem_arb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BEN_WIDTH  = 4
);
    // I-Port
    logic [ADDR_WIDTH-1:0] i_IAddr;
    logic                  i_IRdC;
    logic [DATA_WIDTH-1:0] o_IData;
    logic                  o_IRdy;
    logic                  o_IErr;

    // D-Port
    logic [ADDR_WIDTH-1:0] i_DAddr;
    logic                  i_DCmd;
    logic                  i_DRnW;
    logic [BEN_WIDTH-1:0]  i_DBen;
    logic [DATA_WIDTH-1:0] i_DData;
    logic [DATA_WIDTH-1:0] o_DData;
    logic                  o_DRdy;
    logic                  o_DErr;

    // System memory bus
    logic [ADDR_WIDTH-1:0] o_MAddr;
    logic                  o_MCmd;
    logic                  o_MRnW;
    logic [BEN_WIDTH-1:0]  o_MBen;
    logic [DATA_WIDTH-1:0] o_MData;
    logic [DATA_WIDTH-1:0] i_MData;
    logic                  i_MRdy;
    logic                  i_MErr;

    modport slave (
        input  i_IAddr, i_IRdC,
        output o_IData, o_IRdy, o_IErr,
        input  i_DAddr, i_DCmd, i_DRnW, i_DBen, i_DData,
        output o_DData, o_DRdy, o_DErr,
        output o_MAddr, o_MCmd, o_MRnW, o_MBen, o_MData,
        input  i_MData, i_MRdy, i_MErr
    );

    modport master (
        output i_IAddr, i_IRdC,
        input  o_IData, o_IRdy, o_IErr,
        output i_DAddr, i_DCmd, i_DRnW, i_DBen, i_DData,
        input  o_DData, o_DRdy, o_DErr,
        input  o_MAddr, o_MCmd, o_MRnW, o_MBen, o_MData,
        output i_MData, i_MRdy, i_MErr
    );
endinterface

// File: rtl/uparc_mem_arb.sv
// uparc_mem_arb: shares one single-ported memory bus between the CPU
// instruction fetch port (I) and load/store port (D).
//   clk  : clock
//   nrst : asynchronous active-low reset
//   bus  : uparc_mem_arb_if.slave carrying both CPU ports and the memory bus
// Each port's single-cycle command is captured into a pending slot. One bus
// transaction is issued at a time; when both ports wait, the port that was
// not served last wins. The response is routed combinationally to the port
// that owns the outstanding transaction. An optional watchdog (TIMEOUT>0)
// turns a missing response into an error for the owner.
module uparc_mem_arb #(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter int          BEN_WIDTH  = 4,
    parameter int unsigned TIMEOUT    = 0
) (
    input  logic           clk,
    input  logic           nrst,
    uparc_mem_arb_if.slave bus
);
    localparam logic [15:0] TO16 = 16'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE_I,
        S_ISSUE_D,
        S_WAIT_I,
        S_WAIT_D
    } state_t;

    state_t                state;
    logic                  pend_i;
    logic                  pend_d;
    logic                  last_grant_d;   // 0: I served last, 1: D served last
    logic [15:0]           wd_cnt;

    logic [ADDR_WIDTH-1:0] i_addr_q;
    logic [ADDR_WIDTH-1:0] d_addr_q;
    logic                  d_rnw_q;
    logic [BEN_WIDTH-1:0]  d_ben_q;
    logic [DATA_WIDTH-1:0] d_data_q;

    logic wait_i;
    logic wait_d;
    logic in_wait;
    logic wd_expire;
    logic resp_err;
    logic done;
    logic busy_i;
    logic busy_d;
    logic cap_i;
    logic cap_d;
    logic grant_d;

    assign wait_i  = (state == S_WAIT_I);
    assign wait_d  = (state == S_WAIT_D);
    assign in_wait = wait_i | wait_d;

    // wd_cnt holds the number of WAIT cycles already completed, so the
    // TIMEOUT-th WAIT cycle is the one where it reads TIMEOUT-1.
    assign wd_expire = (TO16 != 16'd0) && in_wait && (wd_cnt == TO16 - 16'd1);

    // A real response in the expiry cycle still wins over the watchdog.
    assign resp_err = bus.i_MErr | (wd_expire & ~bus.i_MRdy);
    assign done     = in_wait & (bus.i_MRdy | resp_err);

    // Response routing; bus responses outside WAIT never reach a port.
    assign bus.o_IData = bus.i_MData;
    assign bus.o_DData = bus.i_MData;
    assign bus.o_IRdy  = wait_i & bus.i_MRdy & ~bus.i_MErr;
    assign bus.o_IErr  = wait_i & resp_err;
    assign bus.o_DRdy  = wait_d & bus.i_MRdy & ~bus.i_MErr;
    assign bus.o_DErr  = wait_d & resp_err;

    // A port is busy from capture until its response; the response cycle
    // itself frees it, so a new command in that cycle is accepted.
    assign busy_i = pend_i | (state == S_ISSUE_I) | (wait_i & ~done);
    assign busy_d = pend_d | (state == S_ISSUE_D) | (wait_d & ~done);
    assign cap_i  = bus.i_IRdC & ~busy_i;
    assign cap_d  = bus.i_DCmd & ~busy_d;

    // Round-robin: D wins when it is the only one waiting, or when both
    // wait and I was served last.
    assign grant_d = pend_d & (~pend_i | ~last_grant_d);

    // NOTE: every register, including the captured command fields, sits on
    // the asynchronous reset so no X can leak onto the bus after power-up.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state        <= S_IDLE;
            pend_i       <= 1'b0;
            pend_d       <= 1'b0;
            last_grant_d <= 1'b0;
            wd_cnt       <= 16'd0;
            i_addr_q     <= '0;
            d_addr_q     <= '0;
            d_rnw_q      <= 1'b0;
            d_ben_q      <= '0;
            d_data_q     <= '0;
            bus.o_MAddr  <= '0;
            bus.o_MCmd   <= 1'b0;
            bus.o_MRnW   <= 1'b0;
            bus.o_MBen   <= '0;
            bus.o_MData  <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch
            // below sees the pre-edge values of state and the pending flags.
            if (cap_i) begin
                pend_i   <= 1'b1;
                i_addr_q <= bus.i_IAddr;
            end
            if (cap_d) begin
                pend_d   <= 1'b1;
                d_addr_q <= bus.i_DAddr;
                d_rnw_q  <= bus.i_DRnW;
                d_ben_q  <= bus.i_DBen;
                d_data_q <= bus.i_DData;
            end

            bus.o_MCmd <= 1'b0;

            case (state)
                // Decides from the registered pending flags only, which
                // gives the two-cycle command-to-bus latency.
                S_IDLE: begin
                    if (pend_i | pend_d) begin
                        bus.o_MCmd <= 1'b1;
                        wd_cnt     <= 16'd0;
                        if (grant_d) begin
                            state        <= S_ISSUE_D;
                            bus.o_MAddr  <= d_addr_q;
                            bus.o_MRnW   <= d_rnw_q;
                            bus.o_MBen   <= d_ben_q;
                            bus.o_MData  <= d_data_q;
                            pend_d       <= 1'b0;
                            last_grant_d <= 1'b1;
                        end else begin
                            state        <= S_ISSUE_I;
                            bus.o_MAddr  <= i_addr_q;
                            bus.o_MRnW   <= 1'b1;
                            bus.o_MBen   <= '1;
                            bus.o_MData  <= '0;
                            pend_i       <= 1'b0;
                            last_grant_d <= 1'b0;
                        end
                    end
                end
                S_ISSUE_I: state <= S_WAIT_I;
                S_ISSUE_D: state <= S_WAIT_D;
                S_WAIT_I, S_WAIT_D: begin
                    if (done) begin
                        state <= S_IDLE;
                    end else if (TO16 != 16'd0) begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
